// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder
//
// Receive side of a multiplexed 7-segment bus. It watches the active-low
// anode select and the active-low segment lines and takes one sample per
// anode activation. Each sample is decoded back to a 4-bit value and passed
// through a per-digit glitch filter. The result is a set of stable per-digit
// values with blank, decimal-point and error flags, plus an update strobe.
//
// Ports
//   clk         in   1             system clock
//   reset       in   1             asynchronous, active-high reset
//   am          in   NUM_DIGITS    anode select, active-low
//   out         in   8             segments, active-low, [7]=a .. [1]=g, [0]=dp
//   digit_val   out  4*NUM_DIGITS  decoded value, digit i in [4i+3:4i]
//   digit_blank out  NUM_DIGITS    digit i shows no segments
//   digit_dp    out  NUM_DIGITS    decimal point of digit i lit
//   digit_err   out  NUM_DIGITS    digit i holds an undecodable pattern
//   anode_err   out  1             sticky: several anodes low after settling
//   upd         out  1             one-cycle pulse when any digit output changes
//
// Optional feature (macro SEG_TIMEOUT_EN): a digit that is not captured for
// TIMEOUT_CYCLES clocks is forced to blank, and upd pulses once.
// ============================================================================
module seg_scan_decoder #(
   parameter int NUM_DIGITS     = 4,
   parameter int SETTLE_CYCLES  = 8,
   parameter int STABLE_SCANS   = 2,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   am,
   input  logic [7:0]              out,
   output logic [4*NUM_DIGITS-1:0] digit_val,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic [NUM_DIGITS-1:0]   digit_dp,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    anode_err,
   output logic                    upd
);

   typedef enum logic [1:0] {WAIT_SEL, SETTLE, CAPTURE, HOLD} state_t;

   typedef struct packed {
      logic [3:0] val;
      logic       blank;
      logic       err;
      logic       dp;
   } sample_t;

   localparam int      IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int      HOLD_W       = $clog2(SETTLE_CYCLES + 1);
   localparam int      MATCH_W      = $clog2(STABLE_SCANS + 1);
   localparam sample_t BLANK_SAMPLE = 7'b0000100;

   logic [NUM_DIGITS-1:0] amS1_q, amS2_q, amPrev_q;
   logic [7:0]            outS1_q, outS2_q;
   logic [HOLD_W-1:0]     holdCnt_q, holdCnt_d;
   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  anodeErr_q;
   logic                  upd_q, upd_d;
   sample_t               cand_q [NUM_DIGITS];
   sample_t               cand_d [NUM_DIGITS];
   sample_t               disp_q [NUM_DIGITS];
   sample_t               disp_d [NUM_DIGITS];
   logic [MATCH_W-1:0]    match_q [NUM_DIGITS];
   logic [MATCH_W-1:0]    match_d [NUM_DIGITS];

   logic                  amChanged, settled, singleLow, multiLow, captureEn;
   logic [2:0]            lowCount;
   logic [IDX_W-1:0]      lowIdx;
   logic [5:0]            decoded;
   sample_t               sample;
   logic [NUM_DIGITS-1:0] stale;

   function automatic logic [2:0] countLow(input logic [NUM_DIGITS-1:0] a);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_DIGITS; i++) n = n + {2'b00, ~a[i]};
      return n;
   endfunction

   function automatic logic [IDX_W-1:0] lowIndex(input logic [NUM_DIGITS-1:0] a);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) if (!a[i]) idx = IDX_W'(i);
      return idx;
   endfunction

   // Returns {val[3:0], blank, err} for the active-low a..g pattern.
   function automatic logic [5:0] decodeSeg(input logic [6:0] seg);
      case (seg)
         7'b0000001: return {4'd0, 2'b00};
         7'b1001111: return {4'd1, 2'b00};
         7'b0010010: return {4'd2, 2'b00};
         7'b0000110: return {4'd3, 2'b00};
         7'b1001100: return {4'd4, 2'b00};
         7'b0100100: return {4'd5, 2'b00};
         7'b0100000: return {4'd6, 2'b00};
         7'b0001111: return {4'd7, 2'b00};
         7'b0000000: return {4'd8, 2'b00};
         7'b0000100: return {4'd9, 2'b00};
         7'b1111111: return {4'd0, 2'b10};
         default:    return {4'd0, 2'b01};
      endcase
   endfunction

   // Two-flop synchronizers for the bus, plus a copy of the previous synced
   // select so any change can be seen. Reset parks everything at "idle bus"
   // so a select held through reset still looks like a fresh activation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         amS1_q     <= '1;
         amS2_q     <= '1;
         amPrev_q   <= '1;
         outS1_q    <= '1;
         outS2_q    <= '1;
         holdCnt_q  <= '0;
         anodeErr_q <= 1'b0;
      end else begin
         amS1_q    <= am;
         amS2_q    <= amS1_q;
         amPrev_q  <= amS2_q;
         outS1_q   <= out;
         outS2_q   <= outS1_q;
         holdCnt_q <= holdCnt_d;
         if (settled && multiLow) anodeErr_q <= 1'b1;
      end
   end

   // Select analysis. holdCnt_d counts how many cycles the synced select
   // has held its value, including this one. It saturates at the settle
   // window. The multiple-low error is judged against the same window.
   always_comb begin
      amChanged = (amS2_q != amPrev_q);
      lowCount  = countLow(amS2_q);
      lowIdx    = lowIndex(amS2_q);
      singleLow = (lowCount == 3'd1);
      multiLow  = (lowCount > 3'd1);
      if (amChanged)                                 holdCnt_d = HOLD_W'(1);
      else if (holdCnt_q == HOLD_W'(SETTLE_CYCLES)) holdCnt_d = holdCnt_q;
      else                                           holdCnt_d = holdCnt_q + HOLD_W'(1);
      settled = (holdCnt_d >= HOLD_W'(SETTLE_CYCLES));
      decoded = decodeSeg(outS2_q[7:1]);
      sample  = {decoded, ~outS2_q[0]};
   end

   // Scan FSM state register and latched digit index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= WAIT_SEL;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic. If the select moves during CAPTURE, the segment
   // sample no longer belongs to the latched digit, so the FSM starts over
   // instead of capturing.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         WAIT_SEL: begin
            if (singleLow) begin
               state_d = SETTLE;
               idx_d   = lowIdx;
            end
         end
         SETTLE: begin
            if (amChanged) begin
               if (singleLow) idx_d   = lowIdx;
               else           state_d = WAIT_SEL;
            end else if (settled) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: state_d = amChanged ? WAIT_SEL : HOLD;
         HOLD:    if (amChanged) state_d = WAIT_SEL;
         default: state_d = WAIT_SEL;
      endcase
   end

   // FSM outputs: a single capture strobe for the latched digit.
   always_comb begin
      captureEn = (state_q == CAPTURE) && !amChanged;
   end

`ifdef SEG_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] refresh_q [NUM_DIGITS];
   logic [TO_W-1:0] refresh_d [NUM_DIGITS];

   // Per-digit refresh counters. A digit goes stale exactly once, on the
   // cycle its counter reaches the limit. The counter then saturates, so
   // the digit does not pulse again while it stays unrefreshed.
   always_comb begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (captureEn && idx_q == IDX_W'(d)) begin
            refresh_d[d] = '0;
            stale[d]     = 1'b0;
         end else begin
            stale[d]     = (refresh_q[d] == TO_W'(TIMEOUT_CYCLES - 1));
            refresh_d[d] = (refresh_q[d] == TO_W'(TIMEOUT_CYCLES)) ? refresh_q[d]
                                                                    : refresh_q[d] + TO_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int d = 0; d < NUM_DIGITS; d++) refresh_q[d] <= '0;
      end else begin
         for (int d = 0; d < NUM_DIGITS; d++) refresh_q[d] <= refresh_d[d];
      end
   end
`else
   assign stale = '0;
`endif

   // Glitch filter. A capture either extends the candidate's match run or
   // restarts it with the new sample. The displayed value follows the
   // candidate only once the run is long enough and the value actually
   // differs, so upd marks real changes only.
   always_comb begin
      upd_d = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         cand_d[d]  = cand_q[d];
         match_d[d] = match_q[d];
         disp_d[d]  = disp_q[d];
         if (captureEn && idx_q == IDX_W'(d)) begin
            if (sample == cand_q[d]) begin
               if (match_q[d] != MATCH_W'(STABLE_SCANS)) match_d[d] = match_q[d] + MATCH_W'(1);
            end else begin
               cand_d[d]  = sample;
               match_d[d] = MATCH_W'(1);
            end
            if (match_d[d] >= MATCH_W'(STABLE_SCANS) && cand_d[d] != disp_q[d]) begin
               disp_d[d] = cand_d[d];
               upd_d     = 1'b1;
            end
         end else if (stale[d] && disp_q[d] != BLANK_SAMPLE) begin
            disp_d[d] = BLANK_SAMPLE;
            upd_d     = 1'b1;
         end
      end
   end

   // Filter and display registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            cand_q[d]  <= BLANK_SAMPLE;
            match_q[d] <= '0;
            disp_q[d]  <= BLANK_SAMPLE;
         end
         upd_q <= 1'b0;
      end else begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            cand_q[d]  <= cand_d[d];
            match_q[d] <= match_d[d];
            disp_q[d]  <= disp_d[d];
         end
         upd_q <= upd_d;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigitOut
      assign digit_val[4*g +: 4] = disp_q[g].val;
      assign digit_blank[g]      = disp_q[g].blank;
      assign digit_err[g]        = disp_q[g].err;
      assign digit_dp[g]         = disp_q[g].dp;
   end

   assign anode_err = anodeErr_q;
   assign upd       = upd_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
// tb_seg_scan_decoder
//
// Directed bench for seg_scan_decoder with 4 digits, settle window 8 and
// 2 matching scans. Each activation holds one anode low for 20 clocks,
// usually followed by a short idle gap. Expected values were worked out by
// hand from the segment table.
// ============================================================================
module tb_seg_scan_decoder;

   logic        clk;
   logic        reset;
   logic [3:0]  am;
   logic [7:0]  out;
   logic [15:0] digit_val;
   logic [3:0]  digit_blank;
   logic [3:0]  digit_dp;
   logic [3:0]  digit_err;
   logic        anode_err;
   logic        upd;

   int compareCount  = 0;
   int mismatchCount = 0;
   int updCount      = 0;

   seg_scan_decoder #(
      .NUM_DIGITS    (4),
      .SETTLE_CYCLES (8),
      .STABLE_SCANS  (2),
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .am         (am),
      .out        (out),
      .digit_val  (digit_val),
      .digit_blank(digit_blank),
      .digit_dp   (digit_dp),
      .digit_err  (digit_err),
      .anode_err  (anode_err),
      .upd        (upd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every update pulse seen outside reset.
   always @(negedge clk) begin
      if (!reset && upd === 1'b1) updCount = updCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one bus state and hold it for a number of clocks.
   task automatic applyStimulus(input logic [3:0] a, input logic [7:0] s, input int cycles);
      am  = a;
      out = s;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      am    = 4'hF;
      out   = 8'hFF;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle bus after reset.
      applyStimulus(4'hF, 8'hFF, 30);
      checkOutput("rst_val",   32'(digit_val),   32'h0000);
      checkOutput("rst_blank", 32'(digit_blank), 32'hF);
      checkOutput("rst_dp",    32'(digit_dp),    32'h0);
      checkOutput("rst_err",   32'(digit_err),   32'h0);
      checkOutput("rst_anode", 32'(anode_err),   32'h0);
      checkOutput("rst_upd",   32'(updCount),    32'd0);

      // Scan "5" on digit0 and "2" on digit1. One round is not enough.
      applyStimulus(4'hE, 8'h49, 20);
      applyStimulus(4'hD, 8'h25, 20);
      checkOutput("one_scan_val", 32'(digit_val),   32'h0000);
      checkOutput("one_scan_upd", 32'(updCount),    32'd0);

      // Second round: digit0 must change exactly 11 clocks into the activation.
      applyStimulus(4'hE, 8'h49, 10);
      checkOutput("lat_pre_val", 32'(digit_val[3:0]), 32'h0);
      applyStimulus(4'hE, 8'h49, 1);
      checkOutput("lat_val",     32'(digit_val[3:0]), 32'h5);
      checkOutput("lat_upd_hi",  32'(upd),            32'h1);
      applyStimulus(4'hE, 8'h49, 1);
      checkOutput("lat_upd_lo",  32'(upd),            32'h0);
      applyStimulus(4'hE, 8'h49, 8);
      applyStimulus(4'hD, 8'h25, 20);
      applyStimulus(4'hE, 8'h49, 20);
      applyStimulus(4'hD, 8'h25, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("scan_val",   32'(digit_val),   32'h0025);
      checkOutput("scan_blank", 32'(digit_blank), 32'hC);
      checkOutput("scan_err",   32'(digit_err),   32'h0);
      checkOutput("scan_upd",   32'(updCount),    32'd2);

      // A single glitched activation of "1" on digit0 is filtered out.
      applyStimulus(4'hE, 8'h9F, 20);
      applyStimulus(4'hD, 8'h25, 20);
      applyStimulus(4'hE, 8'h49, 20);
      applyStimulus(4'hD, 8'h25, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("glitch_val", 32'(digit_val), 32'h0025);
      checkOutput("glitch_upd", 32'(updCount),  32'd2);

      // The same pattern held for two activations is accepted.
      applyStimulus(4'hE, 8'h9F, 20);
      applyStimulus(4'hD, 8'h25, 20);
      applyStimulus(4'hE, 8'h9F, 20);
      applyStimulus(4'hD, 8'h25, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("one_val", 32'(digit_val), 32'h0021);
      checkOutput("one_upd", 32'(updCount),  32'd3);
      checkOutput("pre_anode", 32'(anode_err), 32'h0);

      // Two anodes low at once sets the sticky error and captures nothing.
      applyStimulus(4'hC, 8'h49, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("multi_anode", 32'(anode_err),   32'h1);
      checkOutput("multi_val",   32'(digit_val),   32'h0021);
      checkOutput("multi_blank", 32'(digit_blank), 32'hC);
      checkOutput("multi_upd",   32'(updCount),    32'd3);

      // Undecodable pattern on digit2.
      applyStimulus(4'hB, 8'h6D, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      applyStimulus(4'hB, 8'h6D, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("err_flag",  32'(digit_err),   32'h4);
      checkOutput("err_val",   32'(digit_val),   32'h0021);
      checkOutput("err_blank", 32'(digit_blank), 32'h8);
      checkOutput("err_upd",   32'(updCount),    32'd4);

      // A following "8" clears the error.
      applyStimulus(4'hB, 8'h01, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      applyStimulus(4'hB, 8'h01, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("eight_err", 32'(digit_err), 32'h0);
      checkOutput("eight_val", 32'(digit_val), 32'h0821);
      checkOutput("eight_dp",  32'(digit_dp),  32'h0);
      checkOutput("eight_upd", 32'(updCount),  32'd5);

      // "3" with the decimal point lit on digit3.
      applyStimulus(4'h7, 8'h0C, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      applyStimulus(4'h7, 8'h0C, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("dp_val",    32'(digit_val),   32'h3821);
      checkOutput("dp_flag",   32'(digit_dp),    32'h8);
      checkOutput("dp_blank",  32'(digit_blank), 32'h0);
      checkOutput("dp_upd",    32'(updCount),    32'd6);
      checkOutput("anode_sticky", 32'(anode_err), 32'h1);

      // Reset in the middle of a settle window clears everything at once.
      applyStimulus(4'hE, 8'h1F, 6);
      reset = 1'b1;
      #1;
      checkOutput("midrst_val",   32'(digit_val),   32'h0000);
      checkOutput("midrst_blank", 32'(digit_blank), 32'hF);
      checkOutput("midrst_dp",    32'(digit_dp),    32'h0);
      checkOutput("midrst_anode", 32'(anode_err),   32'h0);
      checkOutput("midrst_upd",   32'(upd),         32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // The select held through reset is a full activation; the next one
      // completes the match with the usual latency.
      applyStimulus(4'hE, 8'h1F, 20);
      applyStimulus(4'hF, 8'hFF, 4);
      applyStimulus(4'hE, 8'h1F, 10);
      checkOutput("post_rst_pre", 32'(digit_val[3:0]), 32'h0);
      applyStimulus(4'hE, 8'h1F, 1);
      checkOutput("post_rst_val", 32'(digit_val[3:0]), 32'h7);
      applyStimulus(4'hE, 8'h1F, 9);
      applyStimulus(4'hF, 8'hFF, 4);
      checkOutput("post_rst_all",   32'(digit_val),   32'h0007);
      checkOutput("post_rst_blank", 32'(digit_blank), 32'hE);
      checkOutput("post_rst_upd",   32'(updCount),    32'd7);

`ifdef SEG_TIMEOUT_EN
      // Show "3" on digit1, then keep scanning digit0 only.
      applyStimulus(4'hD, 8'h0D, 20);
      applyStimulus(4'hE, 8'h1F, 20);
      applyStimulus(4'hD, 8'h0D, 20);
      checkOutput("to_shown", 32'(digit_val), 32'h0037);
      checkOutput("to_upd0",  32'(updCount),  32'd8);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(4'hE, 8'h1F, 20);
         applyStimulus(4'hF, 8'hFF, 4);
      end
      checkOutput("to_before_blank", 32'(digit_blank[1]), 32'h0);
      checkOutput("to_before_val",   32'(digit_val),      32'h0037);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(4'hE, 8'h1F, 20);
         applyStimulus(4'hF, 8'hFF, 4);
      end
      checkOutput("to_blank", 32'(digit_blank[1]), 32'h1);
      checkOutput("to_val",   32'(digit_val),      32'h0007);
      checkOutput("to_upd1",  32'(updCount),       32'd9);
      for (int i = 0; i < 50; i++) begin
         applyStimulus(4'hE, 8'h1F, 20);
         applyStimulus(4'hF, 8'hFF, 4);
      end
      checkOutput("to_no_repeat", 32'(updCount),  32'd9);
      checkOutput("to_d0_kept",   32'(digit_val), 32'h0007);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
